// File: rtl/rst_seq.sv
// rst_seq: reset sequencer that holds all channels for MIN_ASSERT cycles after the
// reset source drops, then releases them one by one in index order, GAP cycles apart.
module rst_seq #(
    parameter int       NUM_CH     = 4,
    parameter int       MIN_ASSERT = 8,
    parameter int       GAP        = 2,
    parameter bit       SEQ_EN     = 1'b1,
    localparam int      RW         = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_rst_req,
    input  logic [NUM_CH-1:0] hold,
    output logic [NUM_CH-1:0] rst_out,
    output logic              busy,
    output logic              done,
    output logic [RW-1:0]     released
);
    localparam int CW = $clog2(MIN_ASSERT + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {S_ASSERT, S_RELEASE, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NUM_CH-1:0] rst_out_q, rst_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [RW-1:0]     released_q, released_d;
    logic              src, fire, last;

    assign src  = rst | sw_rst_req;
    // The targeted channel falls once its gap has elapsed and nothing holds it.
    assign fire = (state_q == S_RELEASE) && (gap_q == '0) && !hold[idx_q];
    assign last = idx_q == IW'(NUM_CH - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_ASSERT;
            cnt_q      <= '0;
            gap_q      <= '0;
            idx_q      <= '0;
            rst_out_q  <= '1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            released_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            idx_q      <= idx_d;
            rst_out_q  <= rst_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            released_q <= released_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        if (src) begin
            state_d = S_ASSERT;
            cnt_d   = '0;
            gap_d   = '0;
            idx_d   = '0;
        end else if (state_q == S_ASSERT) begin
            state_d = (cnt_q == CW'(MIN_ASSERT - 1)) ? S_RELEASE : S_ASSERT;
            cnt_d   = (cnt_q == CW'(MIN_ASSERT - 1)) ? '0 : cnt_q + CW'(1);
        end else if (fire) begin
            state_d = last ? S_RUN : S_RELEASE;
            idx_d   = last ? idx_q : idx_q + IW'(1);
            gap_d   = GW'(GAP - 1);
        end else if (state_q == S_RELEASE && gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end
    end

    always_comb begin
        rst_out_d  = rst_out_q;
        busy_d     = busy_q;
        done_d     = done_q;
        released_d = released_q;
        if (src) begin
            rst_out_d  = '1;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            released_d = '0;
        end else if (fire) begin
            rst_out_d[idx_q] = 1'b0;
            released_d       = released_q + RW'(1);
            busy_d           = !last;
            done_d           = last;
        end
        if (!SEQ_EN) begin
            rst_out_d  = {NUM_CH{src}};
            busy_d     = src;
            done_d     = !src;
            released_d = src ? '0 : RW'(NUM_CH);
        end
    end

    assign rst_out  = rst_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign released = released_q;
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed scoreboard bench for rst_seq in sequenced, bypass and single-channel forms.
module tb_rst_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, sw_a = 1'b0;
    logic [3:0] hold_a = '0, ro_a;
    logic       busy_a, done_a;
    logic [2:0] rel_a;

    logic       rst_b = 1'b1, sw_b = 1'b0;
    logic [3:0] hold_b = '0, ro_b;
    logic       busy_b, done_b;
    logic [2:0] rel_b;

    logic       rst_c = 1'b1, sw_c = 1'b0;
    logic [0:0] hold_c = '0, ro_c, rel_c;
    logic       busy_c, done_c;

    rst_seq u_seq (.clk(clk), .rst(rst_a), .sw_rst_req(sw_a), .hold(hold_a),
                   .rst_out(ro_a), .busy(busy_a), .done(done_a), .released(rel_a));
    rst_seq #(.SEQ_EN(1'b0)) u_byp (.clk(clk), .rst(rst_b), .sw_rst_req(sw_b), .hold(hold_b),
                   .rst_out(ro_b), .busy(busy_b), .done(done_b), .released(rel_b));
    rst_seq #(.NUM_CH(1), .MIN_ASSERT(1)) u_one (.clk(clk), .rst(rst_c), .sw_rst_req(sw_c),
                   .hold(hold_c), .rst_out(ro_c), .busy(busy_c), .done(done_c), .released(rel_c));

    typedef struct {
        string      tag;
        int         dut;
        logic [3:0] ro;
        logic       busy;
        logic       done;
        logic [2:0] rel;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Sequenced outputs follow from the channel pattern: busy while any channel is held.
    task automatic push(input string tag, input int dut, input logic [3:0] ro);
        exp_t x;
        int   z = 0;
        for (int k = 0; k < 4; k++) z += (ro[k] == 1'b0) ? 1 : 0;
        x.tag = tag;
        x.dut = dut;
        x.ro  = ro;
        if (dut == 0) begin
            x.busy = ro != 4'h0;
            x.done = ro == 4'h0;
            x.rel  = 3'(z);
        end else if (dut == 1) begin
            x.busy = ro[0];
            x.done = !ro[0];
            x.rel  = ro[0] ? 3'd0 : 3'd4;
        end else begin
            x.busy = ro[0];
            x.done = !ro[0];
            x.rel  = {2'b00, !ro[0]};
        end
        q.push_back(x);
    endtask

    task automatic edge_chk(input string tag, input int dut, input logic [3:0] ro);
        exp_t x;
        push(tag, dut, ro);
        @(posedge clk);
        #1;
        x = q.pop_front();
        if (x.dut == 0) begin
            cmp({x.tag, "_rst_out"}, 32'(ro_a), 32'(x.ro));
            cmp({x.tag, "_busy"}, 32'(busy_a), 32'(x.busy));
            cmp({x.tag, "_done"}, 32'(done_a), 32'(x.done));
            cmp({x.tag, "_released"}, 32'(rel_a), 32'(x.rel));
        end else if (x.dut == 1) begin
            cmp({x.tag, "_rst_out"}, 32'(ro_b), 32'(x.ro));
            cmp({x.tag, "_busy"}, 32'(busy_b), 32'(x.busy));
            cmp({x.tag, "_done"}, 32'(done_b), 32'(x.done));
            cmp({x.tag, "_released"}, 32'(rel_b), 32'(x.rel));
        end else begin
            cmp({x.tag, "_rst_out"}, 32'(ro_c), 32'(x.ro[0]));
            cmp({x.tag, "_busy"}, 32'(busy_c), 32'(x.busy));
            cmp({x.tag, "_done"}, 32'(done_c), 32'(x.done));
            cmp({x.tag, "_released"}, 32'(rel_c), 32'(x.rel));
        end
    endtask

    function automatic logic [3:0] exp_norm(input int e);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = (e < 30) ? (e < 8 + 2 * k) : (e < 39 + 2 * k);
        return r;
    endfunction

    function automatic logic [3:0] exp_hold(input int e);
        logic [3:0] r;
        r[0] = e < 8;
        r[1] = e < 10;
        r[2] = e < 20;
        r[3] = e < 22;
        return r;
    endfunction

    function automatic logic [3:0] exp_mid(input int e);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = (e < 11) ? (e < 8 + 2 * k) : (e == 11) || (e < 20 + 2 * k);
        return r;
    endfunction

    initial begin
        rst_a = 1'b1;
        repeat (3) edge_chk("norm_rst", 0, 4'hF);
        for (int e = 0; e < 47; e++) begin
            rst_a = (e == 30);
            edge_chk($sformatf("norm_e%0d", e), 0, exp_norm(e));
        end
        rst_a = 1'b1;
        repeat (3) edge_chk("hold_rst", 0, 4'hF);
        rst_a = 1'b0;
        for (int e = 0; e < 26; e++) begin
            hold_a = ((e >= 9) ? 4'b0001 : 4'b0000) | ((e < 12) ? 4'b1000 : 4'b0000)
                   | ((e < 20) ? 4'b0100 : 4'b0000);
            edge_chk($sformatf("hold_e%0d", e), 0, exp_hold(e));
        end
        hold_a = '0;
        rst_a = 1'b1;
        repeat (3) edge_chk("mid_rst", 0, 4'hF);
        rst_a = 1'b0;
        for (int e = 0; e < 29; e++) begin
            sw_a = (e == 11);
            edge_chk($sformatf("mid_e%0d", e), 0, exp_mid(e));
        end
        sw_a = 1'b0;
        hold_b = 4'hF;
        for (int e = 0; e < 10; e++) begin
            rst_b = (e <= 5);
            sw_b  = (e == 8);
            edge_chk($sformatf("byp_e%0d", e), 1, (e <= 5 || e == 8) ? 4'hF : 4'h0);
        end
        rst_c = 1'b1;
        repeat (2) edge_chk("one_rst", 2, 4'h1);
        rst_c = 1'b0;
        for (int e = 0; e < 4; e++) edge_chk($sformatf("one_e%0d", e), 2, (e < 1) ? 4'h1 : 4'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter NUM_CH, default 4, number of reset output channels (1..32).
REQ-002 Parameter MIN_ASSERT, default 8, minimum cycles all channels stay asserted after the reset source drops (>=1).
REQ-003 Parameter GAP, default 2, cycles between consecutive channel releases (>=1).
REQ-004 Parameter SEQ_EN, default 1'b1, 1 = sequenced release, 0 = bypass mode.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 sw_rst_req  input  1  software reset request, level, active-high, synchronous to clk.
REQ-008 hold  input  NUM_CH  per-channel release inhibit (e.g. PLL not locked); hold[k]=1 blocks release of channel k.
REQ-009 rst_out  output  NUM_CH  per-channel reset, active-high, registered.
REQ-010 busy  output  1  sequence in progress (ASSERT or RELEASE state), registered.
REQ-011 done  output  1  all channels released, registered.
REQ-012 released  output  $clog2(NUM_CH+1)  count of channels currently released, registered.

Function
REQ-013 Reset source SRC = rst | sw_rst_req; the two SHALL be treated identically.
REQ-014 States SHALL be ASSERT, RELEASE and RUN.
REQ-015 Any edge with SRC=1 SHALL, in any state, force ASSERT, rst_out all ones, busy=1, done=0, released=0, and clear all counters.
REQ-016 Edge 0 is the first edge with SRC=0. ASSERT SHALL count edges 0..MIN_ASSERT-1, then enter RELEASE targeting channel 0.
REQ-017 Without hold, rst_out[k] SHALL fall at edge MIN_ASSERT + k*GAP.
REQ-018 Channels SHALL release strictly in index order 0..NUM_CH-1, one per release edge; a released channel SHALL stay low until the next SRC=1.
REQ-019 At the scheduled release edge of channel k, if hold[k]=1, the sequencer SHALL stall. rst_out[k] SHALL then fall at the first later edge with hold[k]=0.
REQ-020 GAP for channel k+1 SHALL be measured from the actual release edge of channel k.
REQ-021 hold[k] SHALL be ignored before channel k is targeted and after it is released.
REQ-022 released SHALL increment by 1 on the same edge each channel falls.
REQ-023 On the edge channel NUM_CH-1 falls: state RUN, busy=0, done=1, released=NUM_CH.
REQ-024 RUN SHALL persist until SRC=1.
REQ-025 NUM_CH=1 case: done SHALL assert at edge MIN_ASSERT (no GAP applied).
REQ-026 SRC=1 during RELEASE (mid-sequence) SHALL reassert every channel, including already-released ones, on that edge, and restart from REQ-016.
REQ-027 SRC pulse of one cycle SHALL still produce the full MIN_ASSERT hold.
REQ-028 Bypass, SEQ_EN=0:
- rst_out[k] SHALL equal SRC registered by one cycle for all k.
- busy SHALL equal rst_out[0].
- done SHALL equal ~rst_out[0].
- released SHALL be NUM_CH when done, else 0.
- hold SHALL be ignored.
REQ-029 Counter widths SHALL hold MIN_ASSERT and GAP without wrap; no counter SHALL wrap in RUN.

Reset
REQ-030 Values after any edge with rst=1 (both modes): rst_out all ones, busy=1 (SEQ_EN=1) or 1 (SEQ_EN=0), done=0, released=0, state ASSERT.
REQ-031 Output values before the first clock edge are undefined.

Verification (NUM_CH=4, MIN_ASSERT=8, GAP=2, SEQ_EN=1 unless stated)
REQ-032 Normal release: rst high 3 cycles, low from edge 0, hold=0.
- rst_out[0..3] fall at edges 8, 10, 12, 14.
- done=1 and busy=0 at edge 14.
- released steps 1, 2, 3, 4.
REQ-033 Hold stall: as REQ-032 with hold[2]=1 until edge 19, 0 from edge 20.
- rst_out[2] falls at 20.
- rst_out[3] falls at 22.
- released stays 2 over edges 12..19.
REQ-034 Mid-sequence reset: sw_rst_req=1 for one cycle at edge 11 (channels 0,1 released).
- All rst_out=1 at edge 11.
- Restart from edge 12: channels fall at 20, 22, 24, 26.
REQ-035 Reset in RUN: rst=1 at edge 30.
- rst_out=4'hF, done=0, released=0 at edge 30.
- Rst low from edge 31: rst_out[0] falls at 39.
REQ-036 Bypass (SEQ_EN=0): rst toggles 1->0 at edge 5, hold=4'hF.
- All rst_out fall at edge 6.
- done=1 and released=4 at edge 6.
REQ-037 NUM_CH=1, MIN_ASSERT=1: rst low from edge 0 -> rst_out[0] falls and done=1 at edge 1.
